// File: rtl/operacional_ctrl_pkg.sv
// Shared types, constants and helpers for the lock's normal-operation controller.
package operacional_ctrl_pkg;

  // digits[0] is the most recent key; unused positions hold 4'hF.
  typedef struct packed {
    logic [19:0][3:0] digits;
  } senhaPac_t;

  // bcd[0] is the rightmost display digit.
  typedef struct packed {
    logic [5:0][3:0] bcd;
  } bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    senhaPac_t  senha_master;
    senhaPac_t  senha_1;
    senhaPac_t  senha_2;
    senhaPac_t  senha_3;
    senhaPac_t  senha_4;
  } setupPac_t;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_UNLOCKED,
    ST_DOOR_OPEN,
    ST_BLOCKED,
    ST_SETUP
  } estado_op_t;

  localparam logic [3:0] BCD_BLANK     = 4'hB;
  localparam senhaPac_t  SENHA_VAZIA   = {20{4'hF}};
  localparam senhaPac_t  ENTRADA_VAZIA = {20{4'hE}};
  localparam senhaPac_t  CANCELA       = {20{4'hB}};
  localparam senhaPac_t  MASTER_DEFAULT = {{16{4'hF}}, 16'h1234};

  localparam setupPac_t SETUP_DEFAULT = '{
    bip_status:      1'b1,
    bip_time:        7'd5,
    tranca_aut_time: 7'd5,
    senha_master:    MASTER_DEFAULT,
    senha_1:         SENHA_VAZIA,
    senha_2:         SENHA_VAZIA,
    senha_3:         SENHA_VAZIA,
    senha_4:         SENHA_VAZIA
  };

  // A slot with fewer than four programmed digits is treated as empty.
  function automatic logic senha_match(input senhaPac_t entry, input senhaPac_t stored);
    return (stored.digits[3] != 4'hF) && (entry == stored);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/operacional_ctrl_tick_1s.sv
// Free-running one-second strobe: one-cycle pulse every CLK_HZ clocks.
module tick_1s #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == CW'(CLK_HZ - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
endmodule

// File: rtl/operacional_ctrl.sv
// Normal-operation lock controller: password check, bolt/buzzer, timers, lockout.
// Optional build macro BLOCK_ESCALATE_EN doubles each successive block time (max 99 s).
module operacional_ctrl
  import operacional_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MAX_FALHAS   = 3,
  parameter int BLOCK_TIME_S = 30
) (
  input  logic      clk,
  input  logic      rst,
  input  senhaPac_t digitos_value,
  input  logic      digitos_valid,
  input  logic      sensor_contato,
  input  logic      botao_interno,
  input  setupPac_t data_setup_new,
  input  logic      data_setup_ok,
  output logic      setup_on,
  output logic      tranca,
  output logic      bip,
  output logic      teclado_en,
  output logic      display_en,
  output bcdPac_t   bcd_pac
);
  localparam int FW = $clog2(MAX_FALHAS + 1);

  estado_op_t  state_q, state_d;
  setupPac_t   cfg_q, cfg_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [6:0]  sec_q, sec_d;
  logic [6:0]  rem_q, rem_d;
  logic        tranca_q, tranca_d, bip_q, bip_d, setup_on_q, setup_on_d;
  logic        teclado_en_q, teclado_en_d, display_en_q, display_en_d;
  bcdPac_t     bcd_q, bcd_d;
  logic        tick;
  logic        attempt, match_user, match_master;
  logic [6:0]  block_time;

  tick_1s #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .rst(rst), .tick(tick));

  // Empty, cancel and short entries never reach the password comparison.
  assign attempt = digitos_valid && (digitos_value != ENTRADA_VAZIA)
                && (digitos_value != CANCELA) && (digitos_value.digits[3] != 4'hF);
  assign match_master = senha_match(digitos_value, cfg_q.senha_master);
  assign match_user   = senha_match(digitos_value, cfg_q.senha_1) || senha_match(digitos_value, cfg_q.senha_2)
                     || senha_match(digitos_value, cfg_q.senha_3) || senha_match(digitos_value, cfg_q.senha_4);

`ifdef BLOCK_ESCALATE_EN
  logic [2:0] esc_q, esc_d;

  function automatic logic [6:0] esc_time(input logic [2:0] lvl);
    int bt;
    bt = BLOCK_TIME_S << lvl;
    return (bt > 99) ? 7'd99 : 7'(bt);
  endfunction

  assign block_time = esc_time(esc_q);

  always_comb begin
    esc_d = esc_q;
    if (state_q == ST_LOCKED && state_d == ST_UNLOCKED && !botao_interno)
      esc_d = '0;
    else if (state_q != ST_BLOCKED && state_d == ST_BLOCKED && esc_q != 3'd7)
      esc_d = esc_q + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) esc_q <= '0;
    else     esc_q <= esc_d;
  end
`else
  assign block_time = 7'(BLOCK_TIME_S);
`endif

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    fail_d  = fail_q;
    sec_d   = sec_q;
    rem_d   = rem_q;
    case (state_q)
      ST_LOCKED: begin
        if (botao_interno) begin
          state_d = ST_UNLOCKED;
        end else if (attempt) begin
          if (match_user || match_master) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
          end else if (fail_q == FW'(MAX_FALHAS - 1)) begin
            state_d = ST_BLOCKED;
            fail_d  = '0;
          end else begin
            fail_d = fail_q + FW'(1);
          end
        end
      end
      ST_UNLOCKED: begin
        if (botao_interno)                 state_d = ST_LOCKED;
        else if (!sensor_contato)          state_d = ST_DOOR_OPEN;
        else if (attempt && match_master)  state_d = ST_SETUP;
        else if (tick) begin
          if (sec_q + 7'd1 >= cfg_q.tranca_aut_time) state_d = ST_LOCKED;
          else                                       sec_d   = sec_q + 7'd1;
        end
      end
      ST_DOOR_OPEN: begin
        if (sensor_contato)                state_d = ST_UNLOCKED;
        else if (tick && sec_q != 7'h7F)   sec_d   = sec_q + 7'd1;
      end
      ST_BLOCKED: begin
        if (tick) begin
          if (rem_q <= 7'd1) begin
            state_d = ST_LOCKED;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 7'd1;
          end
        end
      end
      ST_SETUP: begin
        if (data_setup_ok) begin
          cfg_d   = data_setup_new;
          state_d = ST_LOCKED;
        end
      end
      default: state_d = ST_LOCKED;
    endcase
    // Per-state second counters restart on every transition.
    if (state_d != state_q) begin
      sec_d = '0;
      if (state_d == ST_BLOCKED) rem_d = block_time;
    end
  end

  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    tranca_d     = (state_d == ST_LOCKED) || (state_d == ST_BLOCKED);
    teclado_en_d = (state_d == ST_LOCKED) || (state_d == ST_UNLOCKED);
    display_en_d = (state_d == ST_BLOCKED);
    setup_on_d   = (state_d == ST_SETUP) && (state_q != ST_SETUP);
    bip_d        = (state_d == ST_DOOR_OPEN) && cfg_q.bip_status && (sec_d >= cfg_q.bip_time);
    bcd_d        = {6{BCD_BLANK}};
    if (state_d == ST_BLOCKED) bcd_d.bcd[1:0] = to_bcd(rem_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOCKED;
      cfg_q        <= SETUP_DEFAULT;
      fail_q       <= '0;
      sec_q        <= '0;
      rem_q        <= '0;
      tranca_q     <= 1'b1;
      bip_q        <= 1'b0;
      setup_on_q   <= 1'b0;
      teclado_en_q <= 1'b1;
      display_en_q <= 1'b0;
      bcd_q        <= {6{BCD_BLANK}};
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      fail_q       <= fail_d;
      sec_q        <= sec_d;
      rem_q        <= rem_d;
      tranca_q     <= tranca_d;
      bip_q        <= bip_d;
      setup_on_q   <= setup_on_d;
      teclado_en_q <= teclado_en_d;
      display_en_q <= display_en_d;
      bcd_q        <= bcd_d;
    end
  end

  assign tranca     = tranca_q;
  assign bip        = bip_q;
  assign setup_on   = setup_on_q;
  assign teclado_en = teclado_en_q;
  assign display_en = display_en_q;
  assign bcd_pac    = bcd_q;
endmodule

// File: tb/tb_operacional_ctrl.sv
// Directed bench for operacional_ctrl with a queue of expected output vectors.
module tb_operacional_ctrl;
  import operacional_ctrl_pkg::*;

  localparam int W = 29;  // {tranca, bip, setup_on, teclado_en, display_en, bcd[23:0]}

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  senhaPac_t digitos_value = '1;
  logic      digitos_valid = 1'b0;
  logic      sensor_contato = 1'b1;
  logic      botao_interno = 1'b0;
  setupPac_t data_setup_new = '0;
  logic      data_setup_ok = 1'b0;
  logic      setup_on, tranca, bip, teclado_en, display_en;
  bcdPac_t   bcd_pac;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  operacional_ctrl #(.CLK_HZ(10), .MAX_FALHAS(3), .BLOCK_TIME_S(30)) dut (
    .clk(clk), .rst(rst),
    .digitos_value(digitos_value), .digitos_valid(digitos_valid),
    .sensor_contato(sensor_contato), .botao_interno(botao_interno),
    .data_setup_new(data_setup_new), .data_setup_ok(data_setup_ok),
    .setup_on(setup_on), .tranca(tranca), .bip(bip),
    .teclado_en(teclado_en), .display_en(display_en), .bcd_pac(bcd_pac)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  localparam senhaPac_t S_1234 = {{16{4'hF}}, 16'h1234};
  localparam senhaPac_t S_9999 = {{16{4'hF}}, 16'h9999};
  localparam senhaPac_t S_5678 = {{16{4'hF}}, 16'h5678};
  localparam senhaPac_t S_12   = {{18{4'hF}}, 8'h12};
  localparam senhaPac_t S_E    = {20{4'hE}};
  localparam senhaPac_t S_B    = {20{4'hB}};
  localparam logic [23:0] ALL_B = {6{4'hB}};

  function automatic logic [W-1:0] ev(input logic t, input logic b, input logic s,
                                      input logic k, input logic d, input logic [23:0] bcd);
    return {t, b, s, k, d, bcd};
  endfunction

  localparam logic [W-1:0] V_LOCKED = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'hBBBBBB};
  localparam logic [W-1:0] V_UNLOCK = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'hBBBBBB};
  localparam logic [W-1:0] V_DOOR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'hBBBBBB};
  localparam logic [W-1:0] V_BIP    = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'hBBBBBB};
  localparam logic [W-1:0] V_SETON  = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'hBBBBBB};

  function automatic logic [W-1:0] v_blk(input logic [7:0] secs);
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, {16'hBBBB, secs});
  endfunction

  function automatic logic [W-1:0] observed();
    return {tranca, bip, setup_on, teclado_en, display_en, bcd_pac};
  endfunction

  function automatic logic [7:0] read_sig(input int sel);
    case (sel)
      0:       return {7'd0, tranca};
      1:       return {7'd0, bip};
      2:       return {7'd0, display_en};
      default: return bcd_pac.bcd[1:0];
    endcase
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard
  task automatic check_out(input string tag);
    logic [W-1:0] e, o;
    o = observed();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h but no expected value queued", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
    end
  endtask

  task automatic step(input logic [W-1:0] exp, input string tag);
    exp_q.push_back(exp);
    tick();
    check_out(tag);
  endtask

  task automatic strobe(input senhaPac_t e, input logic [W-1:0] exp, input string tag);
    digitos_value = e;
    digitos_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    digitos_valid = 1'b0;
    check_out(tag);
  endtask

  task automatic wait_for(input int sel, input logic [7:0] val, input int lo, input int hi,
                          input string tag);
    int  n;
    bit  hit;
    n   = 0;
    hit = 1'b0;
    while (n < hi + 10) begin
      tick();
      n++;
      if (read_sig(sel) === val) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    assert ((hit && n >= lo && n <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d cycles (reached=%0b) expected %0d..%0d", tag, n, hit, lo, hi);
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    exp_q.push_back(V_LOCKED);
    check_out("reset_values");
    rst = 1'b0;
    step(V_LOCKED, "after_reset");

    // Unlock with the default master, then auto-lock after 5 s
    strobe(S_1234, V_UNLOCK, "unlock_1234");
    wait_for(0, 8'd1, 40, 60, "autolock_5s");
    step(V_LOCKED, "locked_after_auto");

    // Three failures block; display counts down from 30
    strobe(S_9999, V_LOCKED, "fail_1");
    strobe(S_9999, V_LOCKED, "fail_2");
    strobe(S_9999, v_blk(8'h30), "blocked_30");
    wait_for(3, 8'h29, 1, 11, "block_count_29");
    strobe(S_1234, v_blk(8'h29), "blocked_ignores_key");
    botao_interno = 1'b1;
    step(v_blk(8'h29), "blocked_ignores_button");
    botao_interno = 1'b0;
    wait_for(2, 8'd0, 275, 300, "block_end_30s");
    step(V_LOCKED, "locked_after_block");

    // Door open: buzzer after 5 s, cleared when the door closes
    strobe(S_1234, V_UNLOCK, "unlock_door_test");
    sensor_contato = 1'b0;
    step(V_DOOR, "door_open");
    wait_for(1, 8'd1, 40, 60, "bip_after_5s");
    for (int i = 0; i < 10; i++) step(V_BIP, "bip_held");
    sensor_contato = 1'b1;
    step(V_UNLOCK, "door_closed_bip_off");
    wait_for(0, 8'd1, 40, 60, "autolock_after_close");

    // Master while unlocked enters setup; new config takes effect
    strobe(S_1234, V_UNLOCK, "unlock_for_setup");
    strobe(S_1234, V_SETON, "setup_on_pulse");
    step(V_DOOR, "setup_on_cleared");
    sensor_contato = 1'b0;
    step(V_DOOR, "setup_ignores_door");
    sensor_contato = 1'b1;
    data_setup_new = '{bip_status: 1'b1, bip_time: 7'd5, tranca_aut_time: 7'd10,
                       senha_master: S_1234, senha_1: S_5678, senha_2: {20{4'hF}},
                       senha_3: {20{4'hF}}, senha_4: {20{4'hF}}};
    data_setup_ok = 1'b1;
    step(V_LOCKED, "setup_done_locked");
    data_setup_ok = 1'b0;
    strobe(S_E, V_LOCKED, "empty_ignored");
    strobe(S_B, V_LOCKED, "cancel_ignored");
    strobe(S_12, V_LOCKED, "short_1");
    strobe(S_12, V_LOCKED, "short_2");
    strobe(S_9999, V_LOCKED, "fail_after_short_1");
    strobe(S_9999, V_LOCKED, "fail_after_short_2");
    strobe(S_5678, V_UNLOCK, "unlock_5678");
    wait_for(0, 8'd1, 90, 110, "autolock_10s");

    // Button beats a simultaneous strobe; the strobe is not counted
    botao_interno = 1'b1;
    strobe(S_9999, V_UNLOCK, "button_wins");
    step(V_LOCKED, "button_relocks");
    botao_interno = 1'b0;
    strobe(S_9999, V_LOCKED, "counter_was_zero_1");
    strobe(S_9999, V_LOCKED, "counter_was_zero_2");
    strobe(S_9999, v_blk(8'h30), "blocked_again");

    // Asynchronous reset during BLOCKED restores defaults
    rst = 1'b1;
    #2;
    exp_q.push_back(V_LOCKED);
    check_out("async_reset_blocked");
    tick();
    rst = 1'b0;
    strobe(S_5678, V_LOCKED, "cfg_default_rejects_5678");
    strobe(S_1234, V_UNLOCK, "cfg_default_master");
    wait_for(0, 8'd1, 40, 60, "cfg_default_autolock_5s");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/operacional_ctrl.md
Name: operacional_ctrl

Overview:
- Normal-operation controller of the lock (fechadura).
- Holds the active configuration (setupPac_t) and checks keypad passwords against it.
- Drives the bolt and buzzer, runs the auto-lock and door-open timers, and applies failed-attempt lockout.
- Hands control to the setup block when the master password is entered while unlocked.

Parameters:
- CLK_HZ, 50_000_000, clk cycles per 1 s tick.
- MAX_FALHAS, 3, consecutive failed attempts that trigger a block.
- BLOCK_TIME_S, 30, block duration in seconds (1..99).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- digitos_value  in  senhaPac_t  keypad entry; digits[0] is the last key pressed
- digitos_valid  in  1  one-cycle strobe qualifying digitos_value
- sensor_contato  in  1  1 = door closed
- botao_interno  in  1  inside push-button, one-cycle pulse
- data_setup_new  in  setupPac_t  configuration from the setup block
- data_setup_ok  in  1  one-cycle strobe; configuration is valid
- setup_on  out  1  one-cycle request to start setup
- tranca  out  1  1 = bolt engaged
- bip  out  1  buzzer
- teclado_en  out  1  keypad accepted
- display_en  out  1  this block owns the display
- bcd_pac  out  bcdPac_t  display digits

Behaviour:
- Reset values:
  - State LOCKED, tranca=1, bip=0, setup_on=0, teclado_en=1, display_en=0, all BCD=4'hB.
  - Failure counter and timers 0.
  - cfg: bip_status=1, bip_time=5, tranca_aut_time=5, senha_master=16xF,1,2,3,4, senha_1..4 all F.
- Tick generator: pulses 1 cycle every CLK_HZ cycles.
  - Free-running from reset.
  - Each second counter clears on state entry, so timer error is at most 1 s.
- Entry classes (a strobe with digitos_valid=1):
  - All-E (empty) and all-B (cancel): ignored.
  - Entry with digits[3]==F (fewer than 4 keys): ignored, not counted.
  - Otherwise it is an attempt.
  - Match = full 20-digit equality with a stored password whose digits[3]!=F. An unprogrammed slot never matches.
- LOCKED (tranca=1):
  - Matching user password (1..4) or master -> UNLOCKED; failure counter cleared.
  - Non-match -> counter+1. On reaching MAX_FALHAS -> BLOCKED, counter cleared.
  - botao_interno -> UNLOCKED.
  - If a strobe and botao_interno arrive in the same cycle, botao_interno wins and the strobe is discarded.
- UNLOCKED (tranca=0, door closed):
  - Counts tranca_aut_time seconds, then -> LOCKED.
  - sensor_contato=0 -> DOOR_OPEN.
  - botao_interno -> LOCKED immediately.
  - Master password -> SETUP with setup_on pulsed for 1 cycle on entry.
  - Any other attempt is ignored.
- DOOR_OPEN (tranca=0, teclado_en=0):
  - Counts seconds. After bip_time seconds, if cfg.bip_status=1, bip=1 until the door closes.
  - sensor_contato=1 -> UNLOCKED, bip=0 the same cycle, auto-lock timer restarts.
  - botao_interno is ignored.
- BLOCKED (tranca=1, teclado_en=0, display_en=1):
  - BCD1:BCD0 show remaining seconds in BCD; BCD2..5 = B.
  - At 0 -> LOCKED.
  - Strobes and botao_interno are ignored.
- SETUP (tranca=0, teclado_en=0, display_en=0):
  - Waits for data_setup_ok, then latches data_setup_new into cfg the same cycle and goes -> LOCKED.
  - Door opening is ignored; the bolt stays open.
- data_setup_ok outside SETUP is ignored.
- Asynchronous reset mid-operation in any state restores the reset values. cfg returns to defaults; the team accepts that configuration is lost on reset.
- All outputs are registered. The state and tranca change one cycle after the triggering strobe.

Optional Feature:
- Macro: BLOCK_ESCALATE_EN.
- With the macro defined:
  - Each successive block doubles the duration: BLOCK_TIME_S, then 2x, 4x, saturating at 99 s.
  - The escalation level clears on any successful unlock.
- Without it, every block lasts BLOCK_TIME_S.

Decomposition:
- Shared package (alongside senhaPac_t, bcdPac_t, setupPac_t):
  - estado_op_t enum.
  - Constants SENHA_VAZIA={20{4'hF}}, ENTRADA_VAZIA={20{4'hE}}, CANCELA={20{4'hB}}.
  - SETUP_DEFAULT (the reset cfg).
  - Function senha_match(entry, stored).
- One sub-module, tick_1s (parameter CLK_HZ; outputs tick).

Test Plan (CLK_HZ=10):
- Reset, then strobe entry 1234 -> tranca=0 next cycle. Door stays closed -> tranca=1 after 5 ticks (50 cycles +/-10).
- Three strobes of 9999 -> BLOCKED, display 3,0 counting down, keypad strobes ignored. After 30 s -> LOCKED, tranca=1.
- Unlock, then sensor_contato=0 for 6 s -> bip=1 from 5 s on. sensor_contato=1 -> bip=0 the same cycle; tranca=1 5 s later.
- Unlock, enter 1234 -> setup_on for 1 cycle. data_setup_ok with senha_1=...5678, tranca_aut_time=10 -> then 5678 unlocks, auto-lock after 10 s, and entry 12 (short) is not counted.
- botao_interno together with strobe 9999 in LOCKED -> UNLOCKED, failure counter stays 0. Assert rst during BLOCKED -> LOCKED, display_en=0, cfg at defaults.
